// File: rtl/drac_pkg.sv
// Shared core types: LSQ interface, memory instruction encodings and the
// LSQ-to-dcache issuer state machine.
package drac_pkg;

  typedef logic [63:0] reg64_t;
  typedef logic [39:0] regPC_t;
  typedef logic [4:0]  reg_t;

  localparam int unsigned MEM_SIZE_W = 4;
  typedef logic [MEM_SIZE_W-1:0] mem_size_t;

  typedef enum logic [3:0] {
    LD, LW, LWU, LH, LHU, LB, LBU,
    SD, SW, SH, SB
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    regPC_t      pc;
    instr_type_t instr_type;
    reg64_t      addr;
    reg64_t      data;
    mem_size_t   mem_size;
    reg_t        rd;
  } lsq_interface_t;

  typedef enum logic [2:0] {
    IDLE, POP, ISSUE, WAIT_RSP, WB, DRAIN
  } lsq_issuer_state_t;

  // Entry held between the LSQ pop and retirement; data doubles as load result
  typedef struct packed {
    reg64_t      addr;
    reg64_t      data;
    instr_type_t instr_type;
    mem_size_t   mem_size;
    reg_t        rd;
  } lsq_issuer_hold_t;

  function automatic logic is_store(input instr_type_t t);
    return (t == SD) || (t == SW) || (t == SH) || (t == SB);
  endfunction

endpackage

// File: rtl/lsq_mem_issuer.sv
// Pops the LSQ head and issues it to the dcache, one memory operation in
// flight; load results are returned through the writeback port.
module lsq_mem_issuer
  import drac_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  lsq_empty_i,
  input  lsq_interface_t        lsq_instr_i,
  output logic                  read_head_o,
  output logic                  dc_req_valid_o,
  input  logic                  dc_req_ready_i,
  output logic [63:0]           dc_req_addr_o,
  output logic [63:0]           dc_req_data_o,
  output logic                  dc_req_we_o,
  output logic [MEM_SIZE_W-1:0] dc_req_size_o,
  input  logic                  dc_rsp_valid_i,
  input  logic [63:0]           dc_rsp_data_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [63:0]           wb_data_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam logic [7:0] CNT_LAST = 8'(RSP_TIMEOUT - 1);

  lsq_issuer_state_t state_reg, state_next;
  lsq_issuer_hold_t  hold_reg, hold_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              timeout_reg, timeout_next;
  logic              read_head, req_valid, wb_valid;

  logic unused_pc;
  assign unused_pc = ^lsq_instr_i.pc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    read_head    = 1'b0;
    req_valid    = 1'b0;
    wb_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!lsq_empty_i && !flush_i) begin
          read_head  = 1'b1;
          state_next = POP;
        end
      end
      POP: begin
        if (!flush_i && lsq_instr_i.valid) begin
          hold_next.addr       = lsq_instr_i.addr;
          hold_next.data       = lsq_instr_i.data;
          hold_next.instr_type = lsq_instr_i.instr_type;
          hold_next.mem_size   = lsq_instr_i.mem_size;
          hold_next.rd         = lsq_instr_i.rd;
          state_next           = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_next = IDLE;
        end else begin
          req_valid = 1'b1;
          if (dc_req_ready_i) begin
            if (is_store(hold_reg.instr_type)) begin
              state_next = IDLE;
            end else begin
              state_next = WAIT_RSP;
              cnt_next   = '0;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
        // A response coinciding with flush is consumed here, so nothing is left to drain
        if (flush_i) begin
          state_next = dc_rsp_valid_i ? IDLE : DRAIN;
        end else if (dc_rsp_valid_i) begin
          hold_next.data = dc_rsp_data_i;
          state_next     = WB;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = DRAIN;
        end
      end
      WB: begin
        wb_valid   = !flush_i;
        state_next = IDLE;
      end
      DRAIN: begin
        if (dc_rsp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The pop strobe is combinational, so it is also gated by reset itself
  assign read_head_o    = read_head & rstn_i;
  assign dc_req_valid_o = req_valid;
  assign dc_req_addr_o  = hold_reg.addr;
  assign dc_req_data_o  = hold_reg.data;
  assign dc_req_we_o    = is_store(hold_reg.instr_type);
  assign dc_req_size_o  = hold_reg.mem_size;
  assign wb_valid_o     = wb_valid;
  assign wb_rd_o        = hold_reg.rd;
  assign wb_data_o      = hold_reg.data;
  assign busy_o         = (state_reg != IDLE);
  assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_lsq_mem_issuer.sv
// Scoreboard bench for lsq_mem_issuer: an LSQ queue and dcache responder feed
// the DUT while a monitor checks requests and writebacks against expectations.
module tb_lsq_mem_issuer;
  import drac_pkg::*;

  localparam int unsigned RSP_TIMEOUT = 4;

  logic                  clk_i = 1'b0;
  logic                  rstn_i;
  logic                  flush_i;
  logic                  lsq_empty_i;
  lsq_interface_t        lsq_instr_i;
  logic                  read_head_o;
  logic                  dc_req_valid_o;
  logic                  dc_req_ready_i;
  logic [63:0]           dc_req_addr_o;
  logic [63:0]           dc_req_data_o;
  logic                  dc_req_we_o;
  logic [MEM_SIZE_W-1:0] dc_req_size_o;
  logic                  dc_rsp_valid_i;
  logic [63:0]           dc_rsp_data_i;
  logic                  wb_valid_o;
  logic [4:0]            wb_rd_o;
  logic [63:0]           wb_data_o;
  logic                  busy_o;
  logic                  timeout_o;

  always #5 clk_i = ~clk_i;

  lsq_mem_issuer #(.RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .lsq_empty_i(lsq_empty_i), .lsq_instr_i(lsq_instr_i), .read_head_o(read_head_o),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
    .dc_req_addr_o(dc_req_addr_o), .dc_req_data_o(dc_req_data_o),
    .dc_req_we_o(dc_req_we_o), .dc_req_size_o(dc_req_size_o),
    .dc_rsp_valid_i(dc_rsp_valid_i), .dc_rsp_data_i(dc_rsp_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  typedef struct {
    reg64_t    addr;
    reg64_t    data;
    logic      we;
    mem_size_t size;
  } exp_req_t;

  typedef struct {
    logic [4:0] rd;
    reg64_t     data;
  } exp_wb_t;

  lsq_interface_t lsq_q[$];
  exp_req_t       exp_req_q[$];
  exp_wb_t        exp_wb_q[$];

  instr_type_t st_types[4] = '{SD, SW, SH, SB};
  instr_type_t ld_types[7] = '{LD, LW, LWU, LH, LHU, LB, LBU};

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // Stimulus knobs shared with the driver
  bit     rand_ready  = 1'b0;
  bit     ready_level = 1'b1;
  int     rsp_delay   = 0;
  bit     rsp_rand    = 1'b0;
  bit     flush_req   = 1'b0;
  bit     force_rsp   = 1'b0;
  reg64_t force_data  = '0;
  bit     override_en = 1'b0;
  reg64_t override_data = '0;

  function automatic reg64_t resp_data(input reg64_t a);
    return {a[31:0], ~a[31:0]} ^ 64'h5A5A_0F0F_1234_8765;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #3;
  endtask

  task automatic push(input bit st, input reg64_t addr, input reg64_t data,
                      input logic [4:0] rd, input bit want_wb, input reg64_t wb_data);
    lsq_interface_t e;
    exp_req_t       r;
    exp_wb_t        w;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = 40'($urandom);
    e.instr_type = st ? st_types[$urandom_range(0, 3)] : ld_types[$urandom_range(0, 6)];
    e.addr       = addr;
    e.data       = data;
    e.mem_size   = mem_size_t'($urandom_range(0, 3));
    e.rd         = rd;
    lsq_q.push_back(e);
    r.addr = addr; r.data = data; r.we = st; r.size = e.mem_size;
    exp_req_q.push_back(r);
    if (!st && want_wb) begin
      w.rd = rd; w.data = wb_data;
      exp_wb_q.push_back(w);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    step();
    while ((lsq_q.size() != 0 || exp_req_q.size() != 0 || exp_wb_q.size() != 0 || busy_o)
           && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_hs(input string name);
    int n;
    n = 0;
    step();
    while (!(dc_req_valid_o && dc_req_ready_i) && n < 50) begin
      step();
      n++;
    end
    chk({name, "_hs"}, 64'(n < 50), 64'd1);
  endtask

  // LSQ and dcache behaviour: drive at negedge, observe 1 time unit later
  initial begin : driver
    lsq_interface_t pop_entry;
    bit             pop_pend;
    int             rsp_timer;
    reg64_t         rsp_data_q;
    int             d;
    pop_pend = 1'b0; rsp_timer = -1; rsp_data_q = '0; pop_entry = '0;
    flush_i = 1'b0; lsq_empty_i = 1'b1; lsq_instr_i = '0;
    dc_req_ready_i = 1'b0; dc_rsp_valid_i = 1'b0; dc_rsp_data_i = '0;
    forever begin
      @(negedge clk_i);
      lsq_instr_i = '0;
      if (pop_pend) lsq_instr_i = pop_entry;
      lsq_empty_i    = (lsq_q.size() == 0);
      dc_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
      flush_i        = flush_req;
      flush_req      = 1'b0;
      dc_rsp_valid_i = 1'b0;
      dc_rsp_data_i  = '0;
      if (force_rsp) begin
        dc_rsp_valid_i = 1'b1; dc_rsp_data_i = force_data; force_rsp = 1'b0;
      end else if (rsp_timer == 0) begin
        dc_rsp_valid_i = 1'b1; dc_rsp_data_i = rsp_data_q; rsp_timer = -1;
      end else if (rsp_timer > 0) begin
        rsp_timer--;
      end
      #1;
      pop_pend = 1'b0;
      if (read_head_o) begin
        pops++;
        if (lsq_q.size() != 0) begin
          pop_entry = lsq_q.pop_front();
          pop_pend  = 1'b1;
        end
      end
      if (dc_req_valid_o && dc_req_ready_i && !dc_req_we_o) begin
        d = rsp_rand ? int'($urandom_range(0, 2)) : rsp_delay;
        if (d >= 0) begin
          rsp_timer  = d;
          rsp_data_q = override_en ? override_data : resp_data(dc_req_addr_o);
        end
      end
    end
  end

  initial begin : monitor
    exp_req_t er;
    exp_wb_t  ew;
    bit       prev_wb;
    prev_wb = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (read_head_o) chk("pop_legal", {62'd0, busy_o, lsq_empty_i}, 64'd0);
      if (dc_req_valid_o && dc_req_ready_i) begin
        $display("req addr=%h data=%h we=%0b size=%0d", dc_req_addr_o, dc_req_data_o,
                 dc_req_we_o, dc_req_size_o);
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          er = exp_req_q.pop_front();
          chk("req_addr", dc_req_addr_o, er.addr);
          chk("req_data", dc_req_data_o, er.data);
          chk("req_we", 64'(dc_req_we_o), 64'(er.we));
          chk("req_size", 64'(dc_req_size_o), 64'(er.size));
        end
      end
      if (wb_valid_o) begin
        $display("wb rd=%0d data=%h", wb_rd_o, wb_data_o);
        chk("wb_pulse", 64'(prev_wb), 64'd0);
        if (exp_wb_q.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
        end else begin
          ew = exp_wb_q.pop_front();
          chk("wb_rd", 64'(wb_rd_o), 64'(ew.rd));
          chk("wb_data", wb_data_o, ew.data);
        end
      end
      prev_wb = wb_valid_o;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int     p0;
    reg64_t a;
    logic   st;
    rstn_i = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_req_valid", 64'(dc_req_valid_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_addr", dc_req_addr_o, 64'd0);
    rstn_i = 1'b1;
    step();

    // Store: pop at 0, request at 2, idle at 3
    ready_level = 1'b1;
    @(posedge clk_i);
    push(1'b1, 64'h1000, 64'hDEAD, 5'd0, 1'b0, 64'd0);
    step(); chk("st_pop", 64'(read_head_o), 64'd1);
    step(); chk("st_c1_busy", 64'(busy_o), 64'd1);
            chk("st_c1_valid", 64'(dc_req_valid_o), 64'd0);
    step(); chk("st_c2_valid", 64'(dc_req_valid_o), 64'd1);
            chk("st_c2_we", 64'(dc_req_we_o), 64'd1);
            chk("st_c2_data", dc_req_data_o, 64'hDEAD);
    step(); chk("st_c3_idle", 64'(busy_o), 64'd0);
            chk("st_c3_wb", 64'(wb_valid_o), 64'd0);

    // Load under 4 cycles of backpressure, response 2 cycles after handshake
    ready_level = 1'b0; rsp_delay = 1; override_en = 1'b1; override_data = 64'h1234;
    @(posedge clk_i);
    push(1'b0, 64'h2000_0040, 64'h0, 5'd5, 1'b1, 64'h1234);
    step(); chk("bp_pop", 64'(read_head_o), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_stall_valid", 64'(dc_req_valid_o), 64'd1);
      chk("bp_stall_addr", dc_req_addr_o, 64'h2000_0040);
      chk("bp_stall_we", 64'(dc_req_we_o), 64'd0);
    end
    ready_level = 1'b1;
    step(); chk("bp_hs", 64'(dc_req_valid_o & dc_req_ready_i), 64'd1);
    step(); chk("bp_h1_wb", 64'(wb_valid_o), 64'd0);
    step(); chk("bp_h2_wb", 64'(wb_valid_o), 64'd0);
    step(); chk("bp_wb", 64'(wb_valid_o), 64'd1);
            chk("bp_wb_rd", 64'(wb_rd_o), 64'd5);
            chk("bp_wb_data", wb_data_o, 64'h1234);
    step(); chk("bp_wb_once", 64'(wb_valid_o), 64'd0);
            chk("bp_idle", 64'(busy_o), 64'd0);
    override_en = 1'b0;

    // Three back-to-back loads with 1-cycle responses
    rsp_delay = 0;
    p0 = pops;
    @(posedge clk_i);
    for (int i = 0; i < 3; i++) begin
      a = {32'd0, $urandom} & ~64'h7;
      push(1'b0, a, {$urandom, $urandom}, 5'($urandom_range(1, 31)), 1'b1, resp_data(a));
    end
    wait_idle("b2b", 60);
    chk("b2b_pops", 64'(pops - p0), 64'd3);

    // Randomised mix of loads and stores with random ready and response delay
    rand_ready = 1'b1; rsp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      st = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      push(st, a, {$urandom, $urandom}, 5'($urandom), 1'b1, resp_data(a));
    end
    wait_idle("rand", 600);
    rand_ready = 1'b0; rsp_rand = 1'b0; ready_level = 1'b1;

    // Flush one cycle after a load handshake; response arrives 3 cycles later
    rsp_delay = -1;
    @(posedge clk_i);
    push(1'b0, 64'h3000, 64'h0, 5'd9, 1'b0, 64'd0);
    wait_hs("fl");
    flush_req = 1'b1;
    step(); chk("fl_h1_busy", 64'(busy_o), 64'd1);
    step();
    step(); chk("fl_drain_busy", 64'(busy_o), 64'd1);
    force_data = 64'hBAD; force_rsp = 1'b1;
    step(); chk("fl_rsp_busy", 64'(busy_o), 64'd1);
            chk("fl_rsp_wb", 64'(wb_valid_o), 64'd0);
    step(); chk("fl_idle", 64'(busy_o), 64'd0);
            chk("fl_no_wb", 64'(wb_valid_o), 64'd0);
            chk("fl_no_timeout", 64'(timeout_o), 64'd0);

    // Response timeout, then a late response absorbed by the drain
    @(posedge clk_i);
    push(1'b0, 64'h4000, 64'h0, 5'd3, 1'b0, 64'd0);
    wait_hs("to");
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("to_early", 64'(timeout_o), 64'd0);
    end
    step(); chk("to_rise", 64'(timeout_o), 64'd1);
            chk("to_drain", 64'(busy_o), 64'd1);
    step();
    force_data = 64'hFEED; force_rsp = 1'b1;
    step(); chk("to_late_wb", 64'(wb_valid_o), 64'd0);
            chk("to_sticky", 64'(timeout_o), 64'd1);
    step(); chk("to_idle", 64'(busy_o), 64'd0);
            chk("to_sticky2", 64'(timeout_o), 64'd1);

    // Asynchronous reset while a request is pending
    ready_level = 1'b0; rsp_delay = 0;
    @(posedge clk_i);
    push(1'b1, 64'h5000, 64'h77, 5'd0, 1'b0, 64'd0);
    p0 = 0;
    step();
    while (!dc_req_valid_o && p0 < 20) begin
      step();
      p0++;
    end
    chk("rst_mid_issue", 64'(dc_req_valid_o), 64'd1);
    #1 rstn_i = 1'b0;
    #1;
    chk("arst_read_head", 64'(read_head_o), 64'd0);
    chk("arst_req_valid", 64'(dc_req_valid_o), 64'd0);
    chk("arst_addr", dc_req_addr_o, 64'd0);
    chk("arst_data", dc_req_data_o, 64'd0);
    chk("arst_we", 64'(dc_req_we_o), 64'd0);
    chk("arst_size", 64'(dc_req_size_o), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("arst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("arst_wb_data", wb_data_o, 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_timeout", 64'(timeout_o), 64'd0);
    exp_req_q.delete();
    repeat (2) step();
    rstn_i = 1'b1;
    step(); chk("arst_release_idle", 64'(busy_o), 64'd0);
    ready_level = 1'b1;
    @(posedge clk_i);
    push(1'b0, 64'h6000, 64'h1, 5'd7, 1'b1, resp_data(64'h6000));
    wait_idle("arst_resume", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
